// File: rtl/alu_arbiter.sv
// alu_arbiter
// Arbitrates two requesters onto one shared combinational ALU. A granted
// request's op/operands are captured, held on the alu_* outputs, the ALU
// result is registered one cycle later and offered as a response until the
// consumer accepts it. One operation is in flight at a time.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   reqN_valid_i               requester N has an operation pending
//   reqN_op_i/a_i/b_i/shamt_i  requester N operation code and operands
//   reqN_ready_o               one-cycle accept pulse to requester N
//   alu_operation_o/a_o/b_o/shamt_o  captured operation driving the ALU
//   alu_data_i, alu_zero_i     ALU result and zero flag
//   rsp_valid_o/id_o/data_o/zero_o   registered response and its owner
//   rsp_ready_i                response consumer accepts
//
// state | meaning
// IDLE  | waiting for a request; grants one and captures it
// EXEC  | captured op on the ALU; result registered at end of cycle
// RESP  | response valid, held until rsp_ready_i
module alu_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid_i,
  input  logic        req1_valid_i,
  input  logic [3:0]  req0_op_i,
  input  logic [3:0]  req1_op_i,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [4:0]  req0_shamt_i,
  input  logic [4:0]  req1_shamt_i,
  output logic        req0_ready_o,
  output logic        req1_ready_o,
  output logic [3:0]  alu_operation_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [4:0]  alu_shamt_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_zero_i,
  output logic        rsp_valid_o,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_zero_o,
  input  logic        rsp_ready_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic RR_ON = (RR_EN != 0);

  state_t      state_q, state_d;
  logic        last_q;
  logic        req_any;
  logic        grant1;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  shamt_q;
  logic        cap_id_q;
  logic        rsp_id_q, rsp_zero_q;
  logic [31:0] rsp_data_q;

  assign req_any = req0_valid_i | req1_valid_i;
  // Port 1 wins when alone, or in a contest when round-robin is on and
  // port 0 was granted last. last_q resets to 1 so port 0 wins first.
  assign grant1  = req1_valid_i & (~req0_valid_i | (RR_ON & ~last_q));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_any) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so no accept pulse escapes while reset is low.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp_valid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready_o = reset & req0_valid_i & ~grant1;
        req1_ready_o = reset & grant1;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q     <= 1'b1;
      cap_id_q   <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      shamt_q    <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      if (state_q == IDLE && req_any) begin
        last_q   <= grant1;
        cap_id_q <= grant1;
        op_q     <= grant1 ? req1_op_i    : req0_op_i;
        a_q      <= grant1 ? req1_a_i     : req0_a_i;
        b_q      <= grant1 ? req1_b_i     : req0_b_i;
        shamt_q  <= grant1 ? req1_shamt_i : req0_shamt_i;
      end
      if (state_q == EXEC) begin
        rsp_id_q   <= cap_id_q;
        rsp_data_q <= alu_data_i;
        rsp_zero_q <= alu_zero_i;
      end
    end
  end

  assign alu_operation_o = op_q;
  assign alu_a_o         = a_q;
  assign alu_b_o         = b_q;
  assign alu_shamt_o     = shamt_q;
  assign rsp_id_o        = rsp_id_q;
  assign rsp_data_o      = rsp_data_q;
  assign rsp_zero_o      = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
  } req_t;

  localparam logic [3:0] OP_LUI = 4'b0000, OP_OR = 4'b0001, OP_SLL = 4'b0010,
                         OP_ADD = 4'b0011, OP_SRL = 4'b0100, OP_SUB = 4'b0101,
                         OP_AND = 4'b0110;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // main DUT (round-robin)
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
  req_t        r0 = '0, r1 = '0;
  logic        req0_ready, req1_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_data;
  logic [4:0]  alu_sh;
  logic        alu_zero;
  logic        rsp_valid, rsp_id, rsp_zero;
  logic [31:0] rsp_data;

  // fixed-priority DUT, both requesters always valid
  logic        fp_valid = 1'b1, fp_rsp_ready = 1'b1;
  req_t        fp_r0, fp_r1;
  logic        fp_ready0, fp_ready1;
  logic [3:0]  fp_alu_op;
  logic [31:0] fp_alu_a, fp_alu_b, fp_alu_data;
  logic [4:0]  fp_alu_sh;
  logic        fp_alu_zero;
  logic        fp_rsp_valid, fp_rsp_id, fp_rsp_zero;
  logic [31:0] fp_rsp_data;

  assign fp_r0 = '{op: OP_ADD, a: 32'd100, b: 32'd23, sh: 5'd0};
  assign fp_r1 = '{op: OP_SUB, a: 32'd50,  b: 32'd7,  sh: 5'd0};

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_LUI:  return {b[15:0], 16'h0000};
      OP_OR:   return a | b;
      OP_SLL:  return b << sh;
      OP_SRL:  return b >> sh;
      OP_AND:  return a & b;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_data    = alu_fn(alu_op, alu_a, alu_b, alu_sh);
  assign alu_zero    = (alu_data == 32'h0);
  assign fp_alu_data = alu_fn(fp_alu_op, fp_alu_a, fp_alu_b, fp_alu_sh);
  assign fp_alu_zero = (fp_alu_data == 32'h0);

  alu_arbiter #(.RR_EN(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
    .req0_op_i(r0.op), .req1_op_i(r1.op),
    .req0_a_i(r0.a), .req0_b_i(r0.b), .req1_a_i(r1.a), .req1_b_i(r1.b),
    .req0_shamt_i(r0.sh), .req1_shamt_i(r1.sh),
    .req0_ready_o(req0_ready), .req1_ready_o(req1_ready),
    .alu_operation_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_shamt_o(alu_sh),
    .alu_data_i(alu_data), .alu_zero_i(alu_zero),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .rsp_zero_o(rsp_zero), .rsp_ready_i(rsp_ready)
  );

  alu_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid_i(fp_valid), .req1_valid_i(fp_valid),
    .req0_op_i(fp_r0.op), .req1_op_i(fp_r1.op),
    .req0_a_i(fp_r0.a), .req0_b_i(fp_r0.b), .req1_a_i(fp_r1.a), .req1_b_i(fp_r1.b),
    .req0_shamt_i(fp_r0.sh), .req1_shamt_i(fp_r1.sh),
    .req0_ready_o(fp_ready0), .req1_ready_o(fp_ready1),
    .alu_operation_o(fp_alu_op), .alu_a_o(fp_alu_a), .alu_b_o(fp_alu_b),
    .alu_shamt_o(fp_alu_sh),
    .alu_data_i(fp_alu_data), .alu_zero_i(fp_alu_zero),
    .rsp_valid_o(fp_rsp_valid), .rsp_id_o(fp_rsp_id), .rsp_data_o(fp_rsp_data),
    .rsp_zero_o(fp_rsp_zero), .rsp_ready_i(fp_rsp_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard state ----------------
  logic [32:0] exp_q0[$];     // {zero, data} per port, in issue order
  logic [32:0] exp_q1[$];
  logic        model_last = 1'b1;
  logic        busy = 1'b0;
  logic        cur_id = 1'b0;
  req_t        cur_f = '0;
  int          cyc = 0;
  int          grant_cyc = 0;
  int          fp_grants = 0;

  function automatic logic [32:0] expect_of(input req_t r);
    logic [31:0] d;
    d = alu_fn(r.op, r.a, r.b, r.sh);
    return {(d == 32'h0), d};
  endfunction

  // main DUT monitor
  initial begin
    logic        exp_v, exp_id;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc++;
        exp_v = busy && (cyc - grant_cyc >= 2);
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
        if (busy && cyc > grant_cyc) begin
          check("alu_op",    {28'b0, alu_op}, {28'b0, cur_f.op});
          check("alu_a",     alu_a, cur_f.a);
          check("alu_b",     alu_b, cur_f.b);
          check("alu_shamt", {27'b0, alu_sh}, {27'b0, cur_f.sh});
          check("ready_while_busy", {30'b0, req1_ready, req0_ready}, 32'd0);
        end
        if (busy && rsp_valid) begin
          check("rsp_id", {31'b0, rsp_id}, {31'b0, cur_id});
          check("rsp_expected_present",
                {31'b0, (cur_id ? exp_q1.size() : exp_q0.size()) != 0}, 32'd1);
          if ((cur_id ? exp_q1.size() : exp_q0.size()) != 0) begin
            e = cur_id ? exp_q1[0] : exp_q0[0];
            check("rsp_data", rsp_data, e[31:0]);
            check("rsp_zero", {31'b0, rsp_zero}, {31'b0, e[32]});
            if (rsp_ready) begin
              if (cur_id) void'(exp_q1.pop_front());
              else        void'(exp_q0.pop_front());
              busy = 1'b0;
            end
          end
        end else if (!busy && (req0_ready || req1_ready)) begin
          exp_id = (req0_valid && req1_valid) ? ~model_last : req1_valid;
          check("grant", {30'b0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
          model_last = exp_id;
          cur_id     = exp_id;
          cur_f      = exp_id ? r1 : r0;
          busy       = 1'b1;
          grant_cyc  = cyc;
        end else if (!busy) begin
          check("idle_with_request", {31'b0, req0_valid | req1_valid}, 32'd0);
        end
      end
    end
  end

  // fixed-priority DUT monitor
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        check("fp_req1_ready", {31'b0, fp_ready1}, 32'd0);
        if (fp_ready0) fp_grants++;
        if (fp_rsp_valid) begin
          check("fp_rsp_id",   {31'b0, fp_rsp_id}, 32'd0);
          check("fp_rsp_data", fp_rsp_data, 32'd123);
          check("fp_rsp_zero", {31'b0, fp_rsp_zero}, 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic   g0 = 1'b0, g1 = 1'b0;
  logic   auto_reissue = 1'b0;
  logic   grant_log[$];
  longint grant_t[$];
  logic [3:0] ops [7];

  function automatic req_t rand_req();
    req_t r;
    r.op = ops[$urandom_range(0, 6)];
    r.a  = $urandom;
    r.b  = ($urandom_range(0, 3) == 0) ? r.a : $urandom;
    r.sh = 5'($urandom_range(0, 31));
    return r;
  endfunction

  task automatic issue(input logic port, input req_t r);
    if (port) begin
      r1 = r; req1_valid = 1'b1; exp_q1.push_back(expect_of(r));
    end else begin
      r0 = r; req0_valid = 1'b1; exp_q0.push_back(expect_of(r));
    end
  endtask

  // one clock: sample accepts at negedge, requesters react after posedge
  task automatic tick();
    @(negedge clk);
    g0 = req0_ready;
    g1 = req1_ready;
    @(posedge clk);
    #1;
    if (g0) req0_valid = 1'b0;
    if (g1) req1_valid = 1'b0;
    if (g0 || g1) begin
      grant_log.push_back(g1);
      grant_t.push_back($time);
    end
    if (auto_reissue) begin
      if (!req0_valid) issue(1'b0, rand_req());
      if (!req1_valid) issue(1'b1, rand_req());
    end
  endtask

  task automatic wait_grant(input logic port);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      got = port ? g1 : g0;
    end
    check("wait_grant_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (!req0_valid && !req1_valid && !busy) done = 1'b1;
      else tick();
    end
    check("wait_idle_timeout", {31'b0, done}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  rsp_data, 32'd0);
    check("rst_rsp_id",    {31'b0, rsp_id}, 32'd0);
    check("rst_rsp_zero",  {31'b0, rsp_zero}, 32'd0);
    check("rst_alu_op",    {28'b0, alu_op}, 32'd0);
    check("rst_alu_a",     alu_a, 32'd0);
    check("rst_alu_b",     alu_b, 32'd0);
    check("rst_alu_shamt", {27'b0, alu_sh}, 32'd0);
    check("rst_ready",     {28'b0, fp_ready1, fp_ready0, req1_ready, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    busy       = 1'b0;
    model_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ops = '{OP_ADD, OP_SUB, OP_LUI, OP_OR, OP_SLL, OP_SRL, OP_AND};

    // reset state with a request already pending
    issue(1'b0, '{op: OP_ADD, a: 32'd5, b: 32'd7, sh: 5'd0});
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready0",    {31'b0, req0_ready}, 32'd0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_data",  rsp_data, 32'd0);
    check("reset_alu_a",     alu_a, 32'd0);
    reset = 1'b1;

    // single ADD: grant on first edge after release, response 2 cycles later
    tick();
    check("first_grant", {31'b0, g0}, 32'd1);
    tick();
    #3;
    check("add_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("add_rsp_data",  rsp_data, 32'd12);
    check("add_rsp_zero",  {31'b0, rsp_zero}, 32'd0);
    check("add_rsp_id",    {31'b0, rsp_id}, 32'd0);
    tick();
    wait_idle();

    // round-robin contention, continuously valid
    do_reset();
    grant_log.delete();
    grant_t.delete();
    issue(1'b0, rand_req());
    issue(1'b1, rand_req());
    auto_reissue = 1'b1;
    for (int i = 0; i < 30 && grant_log.size() < 4; i++) tick();
    auto_reissue = 1'b0;
    check("rr_grant_count", {31'b0, grant_log.size() >= 4}, 32'd1);
    if (grant_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("rr_grant_order", {31'b0, grant_log[i]}, {31'b0, 1'(i % 2)});
        if (i > 0) check("rr_grant_spacing", 32'(grant_t[i] - grant_t[i-1]), 32'd30);
      end
    end
    wait_idle();

    // backpressure: response held, no new grant until accepted
    rsp_ready = 1'b0;
    issue(1'b1, '{op: OP_SUB, a: 32'd9, b: 32'd9, sh: 5'd0});
    wait_grant(1'b1);
    issue(1'b0, rand_req());
    tick();
    for (int i = 0; i < 5; i++) begin
      #3;
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_rsp_data",  rsp_data, 32'd0);
      check("bp_rsp_zero",  {31'b0, rsp_zero}, 32'd1);
      check("bp_rsp_id",    {31'b0, rsp_id}, 32'd1);
      check("bp_no_grant",  {31'b0, req0_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    wait_idle();

    // reset while in EXEC discards the op
    issue(1'b0, '{op: OP_SLL, a: $urandom, b: 32'd1, sh: 5'd4});
    wait_grant(1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      #3;
      check("post_reset_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    issue(1'b0, '{op: OP_ADD, a: 32'd1, b: 32'd2, sh: 5'd0});
    wait_grant(1'b0);
    tick();
    #3;
    check("post_reset_rsp_data", rsp_data, 32'd3);
    check("post_reset_rsp_id",   {31'b0, rsp_id}, 32'd0);
    tick();
    wait_idle();

    // shift path
    issue(1'b1, '{op: OP_SRL, a: $urandom, b: 32'h8000_0000, sh: 5'd31});
    wait_grant(1'b1);
    #3;
    check("srl_alu_shamt", {27'b0, alu_sh}, 32'd31);
    check("srl_alu_op",    {28'b0, alu_op}, {28'b0, OP_SRL});
    check("srl_exec_no_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    #3;
    check("srl_rsp_data", rsp_data, 32'd1);
    check("srl_rsp_id",   {31'b0, rsp_id}, 32'd1);
    tick();
    wait_idle();

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid && $urandom_range(0, 2) == 0) issue(1'b0, rand_req());
      if (!req1_valid && $urandom_range(0, 2) == 0) issue(1'b1, rand_req());
      tick();
    end
    rsp_ready = 1'b1;
    wait_idle();

    check("fp_port0_grants", {31'b0, fp_grants >= 50}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
